// File: rtl/pla_pkg.sv
// Shared types for the cube-table logic evaluator: FSM state encoding and
// accumulation mode constants.
package pla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SOP  = 1'b0;
  localparam logic MODE_ESOP = 1'b1;

endpackage

// File: rtl/pla_cube_match.sv
// Single-cube literal match: a cube hits when every cared-for input bit
// equals the cube's polarity bit. An empty care mask matches everything.
module pla_cube_match #(
  parameter int N_IN = 15
) (
  input  logic [N_IN-1:0] i_x,
  input  logic [N_IN-1:0] i_care,
  input  logic [N_IN-1:0] i_val,
  output logic            o_match
);

  assign o_match = ~|((i_x ^ i_val) & i_care);

endmodule

// File: rtl/pla_cube_eval.sv
// Time-multiplexed two-level logic evaluator: scans a programmable cube table
// one cube per cycle and accumulates the result as OR (SOP) or XOR (ESOP).
module pla_cube_eval
  import pla_pkg::*;
#(
  parameter  int N_IN    = 15,
  parameter  int N_OUT   = 1,
  parameter  int N_CUBES = 64,
  localparam int CW      = (N_CUBES > 1) ? $clog2(N_CUBES) : 1,
  localparam int NW      = $clog2(N_CUBES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_omask,
  input  logic [NW-1:0]    n_cubes,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  input  logic             in_esop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_y
);

  localparam logic [NW-1:0] N_MAX = NW'(N_CUBES);

  state_t r_state;
  state_t w_state_next;

  logic [N_IN-1:0]  r_care  [N_CUBES];
  logic [N_IN-1:0]  r_val   [N_CUBES];
  logic [N_OUT-1:0] r_omask [N_CUBES];

  logic [N_IN-1:0]  r_x;
  logic             r_esop;
  logic [NW-1:0]    r_n;
  logic [CW-1:0]    r_idx;
  logic [N_OUT-1:0] r_acc;

  logic             w_accept;
  logic             w_cfg_wr;
  logic             w_match;
  logic             w_last;
  logic             w_full;
  logic [NW-1:0]    w_n_clamp;
  logic [N_OUT-1:0] w_hit;
  logic [N_OUT-1:0] w_acc_upd;

  assign cfg_ready = (r_state != SCAN);
  assign w_cfg_wr  = cfg_we && cfg_ready && (int'(cfg_addr) < N_CUBES);
  assign w_n_clamp = (n_cubes > N_MAX) ? N_MAX : n_cubes;

  pla_cube_match #(.N_IN(N_IN)) u_match (
    .i_x     (r_x),
    .i_care  (r_care[r_idx]),
    .i_val   (r_val[r_idx]),
    .o_match (w_match)
  );

  assign w_hit     = w_match ? r_omask[r_idx] : '0;
  assign w_acc_upd = (r_esop == MODE_ESOP) ? (r_acc ^ w_hit) : (r_acc | w_hit);
  assign w_last    = (NW'(r_idx) == (r_n - NW'(1)));
  // SOP can stop as soon as every output is set; ESOP parity never saturates.
  assign w_full    = (r_esop == MODE_SOP) && (&w_acc_upd);
  assign out_y     = r_acc;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = (w_n_clamp == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (w_last || w_full) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the cube table is reset explicitly; a cleared table is part of the
  // visible reset state, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CUBES; i++) begin
        r_care[i]  <= '0;
        r_val[i]   <= '0;
        r_omask[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_care[cfg_addr]  <= cfg_care;
      r_val[cfg_addr]   <= cfg_val;
      r_omask[cfg_addr] <= cfg_omask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_esop <= MODE_SOP;
      r_n    <= '0;
      r_idx  <= '0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_x    <= in_x;
      r_esop <= in_esop;
      r_n    <= w_n_clamp;
      r_idx  <= '0;
      r_acc  <= '0;
    end else if (r_state == SCAN) begin
      r_acc  <= w_acc_upd;
      r_idx  <= r_idx + CW'(1);
    end
  end

endmodule
